segre_mem_arbiter: RTL and testbench

// Parametrised main-memory arbiter/refill engine between NUM_PORTS cache-side requesters ($I, $D, future ports)
// and the single-ported main memory. Each port holds at most one outstanding line request, with optional dirty

---
 rtl/segre_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_segre_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_arbiter.sv
// Main-memory arbiter / refill engine: NUM_PORTS cache-side line requesters share one
// single-ported memory, served round-robin with an optional writeback before each refill.
module segre_mem_arbiter_slot #(
  parameter int ADDR_SIZE = 32,
  parameter int LINE_SIZE = 128
) (
  input  logic                 clk,
  input  logic                 rsn,
  input  logic                 valid,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic                 wb,
  input  logic [ADDR_SIZE-1:0] wb_addr,
  input  logic [LINE_SIZE-1:0] wb_data,
  input  logic                 clr,
  output logic                 ready,
  output logic                 pending,
  output logic [ADDR_SIZE-1:0] q_addr,
  output logic                 q_wb,
  output logic [ADDR_SIZE-1:0] q_wb_addr,
  output logic [LINE_SIZE-1:0] q_wb_data
);
  // ready is its own register (not ~pending) so the port sees a clean flop output
  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      ready     <= 1'b1;
      pending   <= 1'b0;
      q_addr    <= '0;
      q_wb      <= 1'b0;
      q_wb_addr <= '0;
      q_wb_data <= '0;
    end else if (clr) begin
      ready   <= 1'b1;
      pending <= 1'b0;
    end else if (valid && ready) begin
      ready     <= 1'b0;
      pending   <= 1'b1;
      q_addr    <= addr;
      q_wb      <= wb;
      q_wb_addr <= wb_addr;
      q_wb_data <= wb_data;
    end
  end
endmodule

module segre_mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_SIZE = 32,
  parameter int LINE_SIZE = 128
) (
  input  logic                           clk_i,
  input  logic                           rsn_i,
  input  logic [NUM_PORTS-1:0]           req_valid_i,
  output logic [NUM_PORTS-1:0]           req_ready_o,
  input  logic [NUM_PORTS*ADDR_SIZE-1:0] req_addr_i,
  input  logic [NUM_PORTS-1:0]           req_wb_i,
  input  logic [NUM_PORTS*ADDR_SIZE-1:0] req_wb_addr_i,
  input  logic [NUM_PORTS*LINE_SIZE-1:0] req_wb_data_i,
  output logic [NUM_PORTS-1:0]           rsp_valid_o,
  output logic [ADDR_SIZE-1:0]           rsp_addr_o,
  output logic [LINE_SIZE-1:0]           rsp_data_o,
  output logic                           mm_rd_req_o,
  output logic                           mm_wr_req_o,
  output logic [ADDR_SIZE-1:0]           mm_addr_o,
  output logic [LINE_SIZE-1:0]           mm_data_o,
  input  logic [LINE_SIZE-1:0]           mm_data_i,
  input  logic                           mm_data_rdy_i
);
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_SIZE-1:0] LMASK = ADDR_SIZE'(LINE_SIZE/8 - 1);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, RESP} state_t;

  state_t                              state;
  logic [GW-1:0]                       grant, rr, pick;
  logic                                found;
  logic [NUM_PORTS-1:0]                pending, slot_wb;
  logic [NUM_PORTS-1:0][ADDR_SIZE-1:0] slot_addr, slot_wb_addr;
  logic [NUM_PORTS-1:0][LINE_SIZE-1:0] slot_wb_data;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
    segre_mem_arbiter_slot #(.ADDR_SIZE(ADDR_SIZE), .LINE_SIZE(LINE_SIZE)) u_slot (
      .clk       (clk_i),
      .rsn       (rsn_i),
      .valid     (req_valid_i[p]),
      .addr      (req_addr_i[p*ADDR_SIZE +: ADDR_SIZE]),
      .wb        (req_wb_i[p]),
      .wb_addr   (req_wb_addr_i[p*ADDR_SIZE +: ADDR_SIZE]),
      .wb_data   (req_wb_data_i[p*LINE_SIZE +: LINE_SIZE]),
      .clr       (rsp_valid_o[p]),   // slot frees at the end of its response pulse
      .ready     (req_ready_o[p]),
      .pending   (pending[p]),
      .q_addr    (slot_addr[p]),
      .q_wb      (slot_wb[p]),
      .q_wb_addr (slot_wb_addr[p]),
      .q_wb_data (slot_wb_data[p])
    );
  end

  // Round-robin: first pending port after the last grant
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!found && pending[(int'(rr) + i) % NUM_PORTS]) begin
        pick  = GW'((int'(rr) + i) % NUM_PORTS);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state       <= IDLE;
      grant       <= '0;
      rr          <= GW'(NUM_PORTS - 1);
      mm_rd_req_o <= 1'b0;
      mm_wr_req_o <= 1'b0;
      mm_addr_o   <= '0;
      mm_data_o   <= '0;
      rsp_valid_o <= '0;
      rsp_addr_o  <= '0;
      rsp_data_o  <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant <= pick;
          rr    <= pick;
          if (slot_wb[pick]) begin
            state       <= WB_REQ;
            mm_wr_req_o <= 1'b1;
            mm_addr_o   <= slot_wb_addr[pick] & ~LMASK;
            mm_data_o   <= slot_wb_data[pick];
          end else begin
            state       <= RD_REQ;
            mm_rd_req_o <= 1'b1;
            mm_addr_o   <= slot_addr[pick] & ~LMASK;
          end
        end
        WB_REQ: begin
          mm_wr_req_o <= 1'b0;
          state       <= WB_WAIT;
        end
        WB_WAIT: if (mm_data_rdy_i) begin
          state       <= RD_REQ;
          mm_rd_req_o <= 1'b1;
          mm_addr_o   <= slot_addr[grant] & ~LMASK;
        end
        RD_REQ: begin
          mm_rd_req_o <= 1'b0;
          state       <= RD_WAIT;
        end
        RD_WAIT: if (mm_data_rdy_i) begin
          state       <= RESP;
          rsp_valid_o <= NUM_PORTS'(1) << grant;
          rsp_addr_o  <= slot_addr[grant];
          rsp_data_o  <= mm_data_i;
        end
        RESP: begin
          rsp_valid_o <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter (2 ports, 32-bit addr, 128-bit lines).
module tb_segre_mem_arbiter;
  logic         clk = 1'b0;
  logic         rsn = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [63:0]  req_addr = '0;
  logic [1:0]   req_wb = '0;
  logic [63:0]  req_wb_addr = '0;
  logic [255:0] req_wb_data = '0;
  logic [1:0]   rsp_valid;
  logic [31:0]  rsp_addr;
  logic [127:0] rsp_data;
  logic         mm_rd_req, mm_wr_req;
  logic [31:0]  mm_addr;
  logic [127:0] mm_data_o;
  logic [127:0] mm_data_i = '0;
  logic         mm_data_rdy = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  segre_mem_arbiter #(.NUM_PORTS(2), .ADDR_SIZE(32), .LINE_SIZE(128)) dut (
    .clk_i(clk), .rsn_i(rsn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wb_i(req_wb), .req_wb_addr_i(req_wb_addr), .req_wb_data_i(req_wb_data),
    .rsp_valid_o(rsp_valid), .rsp_addr_o(rsp_addr), .rsp_data_o(rsp_data),
    .mm_rd_req_o(mm_rd_req), .mm_wr_req_o(mm_wr_req), .mm_addr_o(mm_addr),
    .mm_data_o(mm_data_o), .mm_data_i(mm_data_i), .mm_data_rdy_i(mm_data_rdy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until the chosen memory request strobe is seen (bounded)
  task automatic wait_req(input string tag, input bit wr);
    int n = 0;
    while (!(wr ? mm_wr_req : mm_rd_req) && n < 20) begin
      step();
      n++;
    end
    chk(tag, {127'b0, (wr ? mm_wr_req : mm_rd_req)}, 128'd1);
  endtask

  // From a request cycle: wait dly cycles, then return d with a 1-cycle rdy pulse
  task automatic serve(input logic [127:0] d, input int dly);
    repeat (dly) step();
    mm_data_i   = d;
    mm_data_rdy = 1'b1;
    step();
    mm_data_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rsn = 1'b0;
    step();
    step();
    rsn = 1'b1;
    step();
  endtask

  initial begin
    logic [31:0] a;
    int p;
    logic [127:0] d;

    // Reset state
    do_reset();
    chk("rst_ready", {126'b0, req_ready}, 128'h3);
    chk("rst_rsp_valid", {126'b0, rsp_valid}, 128'h0);
    chk("rst_mm_req", {126'b0, mm_rd_req, mm_wr_req}, 128'h0);
    chk("rst_mm_addr", {96'b0, mm_addr}, 128'h0);

    // 1: port0 plain refill, memory answers 3 cycles after rd_req
    req_addr[31:0] = 32'h0000_1234;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    chk("t1_ready_low", {126'b0, req_ready}, 128'h2);
    step();
    chk("t1_rd_pulse", {127'b0, mm_rd_req}, 128'h1);
    chk("t1_mm_addr", {96'b0, mm_addr}, 128'h1230);
    step();
    chk("t1_rd_single", {127'b0, mm_rd_req}, 128'h0);
    d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    serve(d, 2);
    chk("t1_rsp_valid", {126'b0, rsp_valid}, 128'h1);
    chk("t1_rsp_addr", {96'b0, rsp_addr}, 128'h1234);
    chk("t1_rsp_data", rsp_data, d);
    step();
    chk("t1_rsp_pulse", {126'b0, rsp_valid}, 128'h0);
    chk("t1_ready_back", {126'b0, req_ready}, 128'h3);
    chk("t1_rsp_hold", {96'b0, rsp_addr}, 128'h1234);

    // 2: simultaneous requests after reset, then 3 rounds of alternation
    do_reset();
    req_addr = {32'h0000_2010, 32'h0000_1000};
    req_valid = 2'b11;
    step();
    req_valid = 2'b00;
    for (int k = 0; k < 6; k++) begin
      p = k % 2;
      a = 32'h1000 * (p + 1) + 32'h10 * k;
      wait_req($sformatf("t2_rd_%0d", k), 1'b0);
      chk($sformatf("t2_addr_%0d", k), {96'b0, mm_addr}, {96'b0, a});
      serve(128'(k + 100), 1);
      chk($sformatf("t2_rsp_%0d", k), {126'b0, rsp_valid}, 128'(2'b01 << p));
      chk($sformatf("t2_rsp_addr_%0d", k), {96'b0, rsp_addr}, {96'b0, a});
      step();
      if (k < 4) begin
        req_addr[p*32 +: 32] = 32'h1000 * (p + 1) + 32'h10 * (k + 2);
        req_valid[p] = 1'b1;
        step();
        req_valid = 2'b00;
      end
    end
    step();

    // 3: port1 with dirty writeback
    req_addr[63:32]     = 32'h0000_3008;
    req_wb              = 2'b10;
    req_wb_addr[63:32]  = 32'h0000_2044;
    req_wb_data[255:128] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    req_wb    = 2'b00;
    wait_req("t3_wr", 1'b1);
    chk("t3_wr_addr", {96'b0, mm_addr}, 128'h2040);
    chk("t3_wr_data", mm_data_o, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    chk("t3_no_rd_yet", {127'b0, mm_rd_req}, 128'h0);
    step();
    chk("t3_wr_single", {127'b0, mm_wr_req}, 128'h0);
    serve(128'h0, 0);
    chk("t3_rd_pulse", {127'b0, mm_rd_req}, 128'h1);
    chk("t3_rd_addr", {96'b0, mm_addr}, 128'h3000);
    serve(128'hABCD, 2);
    chk("t3_rsp_valid", {126'b0, rsp_valid}, 128'h2);
    chk("t3_rsp_addr", {96'b0, rsp_addr}, 128'h3008);
    chk("t3_rsp_data", rsp_data, 128'hABCD);
    step();

    // 4: port0 valid held while pending
    req_addr[31:0] = 32'h0000_4000;
    req_valid = 2'b01;
    step();
    req_addr[31:0] = 32'h0000_5000;
    chk("t4_ready_low", {126'b0, req_ready}, 128'h2);
    wait_req("t4_rd", 1'b0);
    chk("t4_addr", {96'b0, mm_addr}, 128'h4000);
    serve(128'h4444, 1);
    req_valid = 2'b00;
    chk("t4_rsp", {126'b0, rsp_valid}, 128'h1);
    chk("t4_rsp_addr", {96'b0, rsp_addr}, 128'h4000);
    d = '0;
    repeat (4) begin
      step();
      d = d | {126'b0, rsp_valid} | {127'b0, mm_rd_req};
    end
    chk("t4_one_rsp", d, 128'h0);

    // 5: reset during RD_WAIT
    req_addr[31:0] = 32'h0000_6000;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    wait_req("t5_rd", 1'b0);
    step();
    rsn = 1'b0;
    #1;
    chk("t5_ready", {126'b0, req_ready}, 128'h3);
    chk("t5_mm_addr", {96'b0, mm_addr}, 128'h0);
    chk("t5_rsp_data", rsp_data, 128'h0);
    #1 rsn = 1'b1;
    step();
    mm_data_i = 128'h5555;
    mm_data_rdy = 1'b1;
    step();
    mm_data_rdy = 1'b0;
    d = '0;
    repeat (3) begin
      d = d | {126'b0, rsp_valid} | {127'b0, mm_rd_req};
      step();
    end
    chk("t5_no_rsp", d, 128'h0);

    // 6: spurious rdy in IDLE and in RD_REQ
    mm_data_rdy = 1'b1;
    step();
    mm_data_rdy = 1'b0;
    chk("t6_idle_rsp", {126'b0, rsp_valid}, 128'h0);
    chk("t6_idle_rd", {127'b0, mm_rd_req}, 128'h0);
    req_addr[63:32] = 32'h0000_7000;
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    wait_req("t6_rd", 1'b0);
    mm_data_rdy = 1'b1;
    mm_data_i = 128'h6666;
    step();
    mm_data_rdy = 1'b0;
    chk("t6_rdreq_ignored", {126'b0, rsp_valid}, 128'h0);
    serve(128'h7777, 0);
    chk("t6_rsp", {126'b0, rsp_valid}, 128'h2);
    chk("t6_rsp_data", rsp_data, 128'h7777);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
